// File: rtl/axi_rdata_router.sv
// rtl/axi_rdata_router.sv - routes slave R bursts to master ports 0..2 and issues the per-port ID clear request
module axi_rdata_router #(
    parameter int DW       = 32,
    parameter int IDW      = 8,
    parameter int PORT_LSB = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDW-1:0]   s_rid,
    input  logic [DW-1:0]    s_rdata,
    input  logic [1:0]       s_rresp,
    input  logic             s_rlast,
    input  logic             s_rvalid,
    output logic             s_rready,
    input  logic [4*IDW-1:0] sid_tbl,
    output logic [IDW-1:0]   m0_rid,
    output logic [DW-1:0]    m0_rdata,
    output logic [1:0]       m0_rresp,
    output logic             m0_rlast,
    output logic             m0_rvalid,
    input  logic             m0_rready,
    output logic [IDW-1:0]   m1_rid,
    output logic [DW-1:0]    m1_rdata,
    output logic [1:0]       m1_rresp,
    output logic             m1_rlast,
    output logic             m1_rvalid,
    input  logic             m1_rready,
    output logic [IDW-1:0]   m2_rid,
    output logic [DW-1:0]    m2_rdata,
    output logic [1:0]       m2_rresp,
    output logic             m2_rlast,
    output logic             m2_rvalid,
    input  logic             m2_rready,
    output logic             last_0,
    output logic [IDW-1:0]   sid_0,
    output logic             sid_0_vld,
    input  logic             sid_0_clr_rdy,
    output logic             last_1,
    output logic [IDW-1:0]   sid_1,
    output logic             sid_1_vld,
    input  logic             sid_1_clr_rdy,
    output logic             last_2,
    output logic [IDW-1:0]   sid_2,
    output logic             sid_2_vld,
    input  logic             sid_2_clr_rdy,
    output logic             drop_err
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BURST = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
    localparam logic [1:0] ST_CLEAR = 2'd3;

    logic [1:0]     r_state;
    logic [1:0]     r_port;
    logic [IDW-1:0] r_id;
    logic [IDW-1:0] r_rid;
    logic [DW-1:0]  r_rdata;
    logic [1:0]     r_rresp;
    logic           r_rlast;
    logic           r_rvalid;
    logic           r_clr;
    logic           r_drop_err;

    logic [1:0]     w_sport;
    logic           w_match;
    logic           w_hit;
    logic           w_out_rdy;
    logic           w_clr_rdy;
    logic           w_s_rready;
    logic           w_acc;
    logic           w_load;
    logic           w_drain;

    assign w_sport = s_rid[PORT_LSB +: 2];

    always_comb begin
        w_match = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (sid_tbl[k*IDW +: IDW] == s_rid) w_match = 1'b1;
        end
    end

    assign w_hit = (s_rid != '0) && (w_sport != 2'd3) && w_match;

    always_comb begin
        w_out_rdy = 1'b0;
        w_clr_rdy = 1'b0;
        case (r_port)
            2'd0:    begin w_out_rdy = m0_rready; w_clr_rdy = sid_0_clr_rdy; end
            2'd1:    begin w_out_rdy = m1_rready; w_clr_rdy = sid_1_clr_rdy; end
            2'd2:    begin w_out_rdy = m2_rready; w_clr_rdy = sid_2_clr_rdy; end
            default: begin w_out_rdy = 1'b0;      w_clr_rdy = 1'b0;          end
        endcase
    end

    always_comb begin
        w_s_rready = 1'b0;
        case (r_state)
            ST_IDLE:  w_s_rready = !r_rvalid;
            ST_BURST: w_s_rready = !r_rvalid || w_out_rdy;
            ST_DROP:  w_s_rready = 1'b1;
            default:  w_s_rready = 1'b0;
        endcase
    end

    // Held low while reset is asserted so the slave never sees ready during reset.
    assign s_rready = w_s_rready && !rst;
    assign w_acc    = s_rvalid && s_rready;
    assign w_drain  = r_rvalid && w_out_rdy;
    assign w_load   = w_acc && (((r_state == ST_IDLE) && w_hit) || (r_state == ST_BURST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_port     <= 2'd0;
            r_id       <= '0;
            r_rid      <= '0;
            r_rdata    <= '0;
            r_rresp    <= 2'd0;
            r_rlast    <= 1'b0;
            r_rvalid   <= 1'b0;
            r_clr      <= 1'b0;
            r_drop_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_rvalid <= 1'b1;
                r_rdata  <= s_rdata;
                r_rresp  <= s_rresp;
                r_rlast  <= s_rlast;
                r_rid    <= (r_state == ST_IDLE) ? s_rid : r_id;
            end else if (w_drain) begin
                r_rvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_acc) begin
                        if (w_hit) begin
                            r_port  <= w_sport;
                            r_id    <= s_rid;
                            r_state <= s_rlast ? ST_CLEAR : ST_BURST;
                        end else begin
                            r_drop_err <= 1'b1;
                            if (!s_rlast) r_state <= ST_DROP;
                        end
                    end
                end
                ST_BURST: begin
                    if (w_acc && s_rlast) r_state <= ST_CLEAR;
                end
                ST_DROP: begin
                    if (w_acc && s_rlast) r_state <= ST_IDLE;
                end
                default: begin
                    // In CLEAR the output register can only hold the final beat.
                    if (!r_clr && w_drain) begin
                        r_clr <= 1'b1;
                    end else if (r_clr && w_clr_rdy) begin
                        r_clr   <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign m0_rvalid = r_rvalid && (r_port == 2'd0);
    assign m1_rvalid = r_rvalid && (r_port == 2'd1);
    assign m2_rvalid = r_rvalid && (r_port == 2'd2);

    assign m0_rid   = r_rid;
    assign m0_rdata = r_rdata;
    assign m0_rresp = r_rresp;
    assign m0_rlast = r_rlast;
    assign m1_rid   = r_rid;
    assign m1_rdata = r_rdata;
    assign m1_rresp = r_rresp;
    assign m1_rlast = r_rlast;
    assign m2_rid   = r_rid;
    assign m2_rdata = r_rdata;
    assign m2_rresp = r_rresp;
    assign m2_rlast = r_rlast;

    assign last_0    = r_clr && (r_port == 2'd0);
    assign last_1    = r_clr && (r_port == 2'd1);
    assign last_2    = r_clr && (r_port == 2'd2);
    assign sid_0_vld = last_0;
    assign sid_1_vld = last_1;
    assign sid_2_vld = last_2;
    assign sid_0     = last_0 ? r_id : '0;
    assign sid_1     = last_1 ? r_id : '0;
    assign sid_2     = last_2 ? r_id : '0;

    assign drop_err = r_drop_err;
endmodule

// File: tb/tb_axi_rdata_router.sv
// tb/tb_axi_rdata_router.sv - directed and randomized bursts checked against a queue-based routing model
module tb_axi_rdata_router;
    localparam int DW  = 32;
    localparam int IDW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [IDW-1:0] s_rid;
    logic [DW-1:0]  s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rlast;
    logic           s_rvalid;
    logic           s_rready;
    logic [IDW-1:0] tbl [4];
    logic [4*IDW-1:0] sid_tbl;
    logic [IDW-1:0] m_rid   [3];
    logic [DW-1:0]  m_rdata [3];
    logic [1:0]     m_rresp [3];
    logic [2:0]     m_rlast;
    logic [2:0]     m_rvalid;
    logic [2:0]     m_rready;
    logic [2:0]     lastv;
    logic [IDW-1:0] sid_v   [3];
    logic [2:0]     svld;
    logic [2:0]     clr_rdy;
    logic           drop_err;

    assign sid_tbl = {tbl[3], tbl[2], tbl[1], tbl[0]};

    axi_rdata_router #(.DW(DW), .IDW(IDW), .PORT_LSB(6)) dut (
        .clk(clk), .rst(rst),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .sid_tbl(sid_tbl),
        .m0_rid(m_rid[0]), .m0_rdata(m_rdata[0]), .m0_rresp(m_rresp[0]), .m0_rlast(m_rlast[0]),
        .m0_rvalid(m_rvalid[0]), .m0_rready(m_rready[0]),
        .m1_rid(m_rid[1]), .m1_rdata(m_rdata[1]), .m1_rresp(m_rresp[1]), .m1_rlast(m_rlast[1]),
        .m1_rvalid(m_rvalid[1]), .m1_rready(m_rready[1]),
        .m2_rid(m_rid[2]), .m2_rdata(m_rdata[2]), .m2_rresp(m_rresp[2]), .m2_rlast(m_rlast[2]),
        .m2_rvalid(m_rvalid[2]), .m2_rready(m_rready[2]),
        .last_0(lastv[0]), .sid_0(sid_v[0]), .sid_0_vld(svld[0]), .sid_0_clr_rdy(clr_rdy[0]),
        .last_1(lastv[1]), .sid_1(sid_v[1]), .sid_1_vld(svld[1]), .sid_1_clr_rdy(clr_rdy[1]),
        .last_2(lastv[2]), .sid_2(sid_v[2]), .sid_2_vld(svld[2]), .sid_2_clr_rdy(clr_rdy[2]),
        .drop_err(drop_err)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_hit(input logic [IDW-1:0] id);
        if (id == '0 || id[7:6] == 2'd3) return 1'b0;
        for (int k = 0; k < 4; k++) if (tbl[k] == id) return 1'b1;
        return 1'b0;
    endfunction

    typedef struct {
        logic [DW-1:0] d;
        logic [1:0]    r;
        logic          l;
        int            c;
    } beat_t;

    task automatic run_burst(input logic [IDW-1:0] id, input int n, input logic [DW-1:0] base,
                             input int stall_at, input int stall_len, input int clr_wait,
                             input bit rnd_rdy, input int abort_at);
        beat_t q[$];
        bit hit = model_hit(id);
        int p = int'(id[7:6]);
        logic [2:0] pm = (hit) ? (3'b001 << p) : 3'b000;
        int sent = 0, dlv = 0, stall_cnt = 0, vld_cnt = 0, last_dlv_cyc = 0, guard = 0;
        bit done = 1'b0, hs_seen = 1'b0, head_seen = 1'b0, acc, dl;
        while (!done && guard < 300) begin
            guard++;
            s_rvalid = (sent < n);
            s_rid    = (sent == 0 || !hit) ? id : IDW'($urandom);
            s_rdata  = base + DW'(sent);
            s_rresp  = 2'(sent);
            s_rlast  = (sent == n - 1);
            m_rready = 3'($urandom);
            clr_rdy  = 3'($urandom);
            if (hit) begin
                m_rready[p] = rnd_rdy ? ($urandom_range(0, 3) != 0)
                                      : !(dlv == stall_at && stall_cnt < stall_len);
                clr_rdy[p]  = (vld_cnt >= clr_wait);
            end
            @(negedge clk);
            acc = s_rvalid && s_rready;
            dl  = 1'b0;
            chk("silent_ports", {m_rvalid & ~pm, svld & ~pm, lastv & ~pm}, 9'd0);
            if (!hit) begin
                chk("drop_no_out", {m_rvalid, svld}, 6'd0);
                if (s_rvalid) begin
                    chk("drop_s_rready", s_rready, 1'b1);
                end else begin
                    chk("drop_err_set", drop_err, 1'b1);
                    chk("drop_idle_rdy", s_rready, 1'b1);
                    done = 1'b1;
                end
            end else begin
                chk("out_valid", m_rvalid[p], q.size() != 0);
                if (m_rvalid[p] && q.size() != 0) begin
                    if (!head_seen) chk("beat_latency", cyc, q[0].c + 1);
                    head_seen = 1'b1;
                    chk("beat_data", m_rdata[p], q[0].d);
                    chk("beat_resp", m_rresp[p], q[0].r);
                    chk("beat_last", m_rlast[p], q[0].l);
                    chk("beat_rid", m_rid[p], id);
                    dl = m_rready[p];
                end
                if (sent < n) chk("s_rready_burst", s_rready, !m_rvalid[p] || m_rready[p]);
                else if (!hs_seen) chk("s_rready_clear", s_rready, 1'b0);
                if (hs_seen) begin
                    chk("clr_release", {svld[p], lastv[p], sid_v[p]}, 10'd0);
                    chk("idle_rdy", s_rready, 1'b1);
                    done = 1'b1;
                end else if (svld[p]) begin
                    if (vld_cnt == 0) chk("clr_latency", cyc, last_dlv_cyc + 1);
                    chk("clr_all_delivered", dlv, n);
                    chk("clr_last", lastv[p], 1'b1);
                    chk("clr_sid", sid_v[p], id);
                    vld_cnt++;
                    if (clr_rdy[p]) begin
                        chk("clr_hold_cycles", vld_cnt, clr_wait + 1);
                        hs_seen = 1'b1;
                    end
                end else begin
                    chk("clr_idle", {lastv[p], sid_v[p]}, 9'd0);
                end
                if (m_rvalid[p] && !m_rready[p] && dlv == stall_at) stall_cnt++;
                if (dl) begin
                    void'(q.pop_front());
                    dlv++;
                    head_seen = 1'b0;
                    last_dlv_cyc = cyc;
                end
                if (acc) q.push_back('{d: s_rdata, r: s_rresp, l: s_rlast, c: cyc});
            end
            if (acc) sent++;
            @(posedge clk);
            #1;
            if (abort_at > 0 && sent == abort_at) break;
        end
        if (!done && abort_at == 0) chk("burst_timeout", done, 1'b1);
        s_rvalid = 1'b0;
    endtask

    initial begin
        logic [IDW-1:0] rid;
        s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = 2'd0; s_rlast = 1'b0;
        m_rready = 3'd0; clr_rdy = 3'd0;
        for (int k = 0; k < 4; k++) tbl[k] = '0;
        #12;
        chk("rst_s_rready", s_rready, 1'b0);
        chk("rst_rvalid", m_rvalid, 3'd0);
        chk("rst_clr", {svld, lastv}, 6'd0);
        chk("rst_sid1", sid_v[1], 8'd0);
        chk("rst_payload", m_rdata[0], 32'd0);
        chk("rst_drop_err", drop_err, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        tbl[0] = 8'h41;
        chk("idle_s_rready", s_rready, 1'b1);

        run_burst(8'h41, 4, 32'd1, -1, 0, 0, 1'b0, 0);
        run_burst(8'h41, 4, 32'd1, 2, 3, 0, 1'b0, 0);
        run_burst(8'h41, 4, 32'd1, -1, 0, 5, 1'b0, 0);
        chk("drop_err_clean", drop_err, 1'b0);
        run_burst(8'h55, 3, 32'd10, -1, 0, 0, 1'b0, 0);

        tbl[1] = 8'hC2; tbl[2] = 8'h02; tbl[3] = 8'h85;
        run_burst(8'hC2, 1, 32'd20, -1, 0, 0, 1'b0, 0);
        run_burst(8'h02, 3, 32'd30, -1, 0, 1, 1'b0, 0);

        run_burst(8'h85, 5, 32'd40, -1, 0, 0, 1'b0, 2);
        m_rready = 3'd0;
        chk("pre_rst_m2_valid", m_rvalid[2], 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_m2_valid", m_rvalid[2], 1'b0);
        chk("async_rst_sid2_vld", svld[2], 1'b0);
        chk("async_rst_s_rready", s_rready, 1'b0);
        chk("async_rst_drop_err", drop_err, 1'b0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        run_burst(8'h85, 3, 32'd50, -1, 0, 2, 1'b0, 0);
        chk("post_rst_drop_err", drop_err, 1'b0);

        for (int i = 0; i < 14; i++) begin
            rid = ($urandom_range(0, 3) == 0) ? IDW'($urandom) : tbl[$urandom_range(0, 3)];
            run_burst(rid, $urandom_range(1, 6), DW'($urandom), -1, 0,
                      $urandom_range(0, 3), 1'b1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
